// File: rtl/fpn_pkg.sv
// Shared definitions for the fp_normalizer slice: FSM encoding, field widths,
// exponent limits and the packed single-precision result layout.
package fpn_pkg;

  localparam int unsigned FPN_EXP_W  = 8;
  localparam int unsigned FPN_FRAC_W = 23;

  localparam logic [7:0] EXP_MAX       = 8'hFF;
  localparam logic [7:0] EXP_OVF_LIMIT = 8'd254;

  localparam int unsigned RES_FRAC_LSB = 0;
  localparam int unsigned RES_EXP_LSB  = FPN_FRAC_W;
  localparam int unsigned RES_SIGN_BIT = FPN_FRAC_W + FPN_EXP_W;
  localparam int unsigned RES_W        = FPN_FRAC_W + FPN_EXP_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } fpn_state_e;

endpackage

// File: rtl/fp_normalizer_if.sv
// Upstream sum / downstream result handshake bundle for fp_normalizer.
// master = adder datapath and result consumer side, slave = the normalizer.
interface fp_normalizer_if #(
  parameter int unsigned EXP_W  = fpn_pkg::FPN_EXP_W,
  parameter int unsigned FRAC_W = fpn_pkg::FPN_FRAC_W
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    sign_in;
  logic [EXP_W-1:0]        exp_in;
  logic [FRAC_W+1:0]       mant_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W:0]   result;
  logic                    zero_flag;
  logic                    ovf_flag;
  logic                    uf_flag;

  modport master (
    output in_valid, sign_in, exp_in, mant_in, out_ready,
    input  in_ready, out_valid, result, zero_flag, ovf_flag, uf_flag
  );

  modport slave (
    input  in_valid, sign_in, exp_in, mant_in, out_ready,
    output in_ready, out_valid, result, zero_flag, ovf_flag, uf_flag
  );
endinterface

// File: rtl/fpn_step.sv
// Combinational single normalization step: one shift decision per call.
// FPN_ROUND_EN selects round-to-nearest-even on the carry right shift.
module fpn_step
  import fpn_pkg::*;
#(
  parameter int unsigned EXP_W  = FPN_EXP_W,
  parameter int unsigned FRAC_W = FPN_FRAC_W
) (
  input  logic [FRAC_W+1:0] mant_i,
  input  logic [EXP_W-1:0]  exp_i,
  output logic [FRAC_W+1:0] next_mant_o,
  output logic [EXP_W-1:0]  next_exp_o,
  output logic              done_o,
  output logic              zero_o,
  output logic              ovf_o,
  output logic              uf_o
);

  localparam logic [EXP_W-1:0] EMAX = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] ELIM = EXP_W'(EXP_OVF_LIMIT);

  logic [FRAC_W+1:0] shifted;
  logic [FRAC_W+1:0] rounded;

  always_comb begin
    shifted = mant_i >> 1;
`ifdef FPN_ROUND_EN
    rounded = shifted + (FRAC_W+2)'(mant_i[0] & shifted[0]);
`else
    rounded = shifted;
`endif

    next_mant_o = mant_i;
    next_exp_o  = exp_i;
    done_o      = 1'b0;
    zero_o      = 1'b0;
    ovf_o       = 1'b0;
    uf_o        = 1'b0;

    if (mant_i == '0) begin
      done_o     = 1'b1;
      zero_o     = 1'b1;
      next_exp_o = '0;
    end else if (mant_i[FRAC_W+1] && exp_i == ELIM) begin
      done_o      = 1'b1;
      ovf_o       = 1'b1;
      next_exp_o  = EMAX;
      next_mant_o = '0;
    end else if (mant_i[FRAC_W+1]) begin
      // A rounding carry back into bit FRAC_W+1 needs another right shift.
      next_mant_o = rounded;
      next_exp_o  = exp_i + EXP_W'(1);
      done_o      = ~rounded[FRAC_W+1];
    end else if (mant_i[FRAC_W]) begin
      done_o = 1'b1;
    end else if (exp_i <= EXP_W'(1)) begin
      done_o     = 1'b1;
      uf_o       = 1'b1;
      next_exp_o = '0;
    end else begin
      next_mant_o = mant_i << 1;
      next_exp_o  = exp_i - EXP_W'(1);
    end
  end

endmodule

// File: rtl/fp_normalizer.sv
// Iterative post-add normalizer: one bit position per clock, packed IEEE-754
// output with zero/overflow/underflow flags. Optional macro: FPN_ROUND_EN.
module fp_normalizer
  import fpn_pkg::*;
#(
  parameter int unsigned EXP_W  = FPN_EXP_W,
  parameter int unsigned FRAC_W = FPN_FRAC_W
) (
  input  logic           clk,
  input  logic           reset,
  fp_normalizer_if.slave bus
);

  localparam logic [EXP_W-1:0] EMAX = EXP_W'(EXP_MAX);

  fpn_state_e            state_q, state_d;
  logic                  sign_q, sign_d;
  logic [EXP_W-1:0]      exp_q, exp_d;
  logic [FRAC_W+1:0]     mant_q, mant_d;
  logic [RES_W-1:0]      result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  ovf_q, ovf_d;
  logic                  uf_q, uf_d;

  logic [FRAC_W+1:0]     step_mant;
  logic [EXP_W-1:0]      step_exp;
  logic                  step_done, step_zero, step_ovf, step_uf;

  fpn_step #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_step (
    .mant_i      (mant_q),
    .exp_i       (exp_q),
    .next_mant_o (step_mant),
    .next_exp_o  (step_exp),
    .done_o      (step_done),
    .zero_o      (step_zero),
    .ovf_o       (step_ovf),
    .uf_o        (step_uf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      uf_q     <= uf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    uf_d     = uf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sign_d = bus.sign_in;
          exp_d  = bus.exp_in;
          mant_d = bus.mant_in;
          if (bus.exp_in == EMAX) begin
            result_d                             = '0;
            result_d[RES_SIGN_BIT]               = bus.sign_in;
            result_d[RES_EXP_LSB +: EXP_W]       = EMAX;
            result_d[RES_FRAC_LSB +: FRAC_W]     = bus.mant_in[FRAC_W-1:0];
            state_d                              = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        mant_d = step_mant;
        exp_d  = step_exp;
        if (step_done) begin
          result_d                         = '0;
          result_d[RES_SIGN_BIT]           = sign_q;
          result_d[RES_EXP_LSB +: EXP_W]   = step_exp;
          result_d[RES_FRAC_LSB +: FRAC_W] = step_mant[FRAC_W-1:0];
          zero_d                           = step_zero;
          ovf_d                            = step_ovf;
          uf_d                             = step_uf;
          state_d                          = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          uf_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero_flag = zero_q;
  assign bus.ovf_flag  = ovf_q;
  assign bus.uf_flag   = uf_q;

endmodule
